// File: rtl/bird_pkg.sv
// Shared types and default geometry for the flappy-bird vertical-motion block.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    DEAD
  } bird_state_t;

  localparam int BIRD_ROWS      = 8;
  localparam int BIRD_START_ROW = 4;
  localparam int POS_W          = $clog2(BIRD_ROWS);

endpackage

// File: rtl/bird_motion_tick_gen.sv
// Gravity counter: counts enabled cycles and strobes tick on the wrap cycle (DIV-1).
// The strobe is combinational so the parent can register it together with pos.
module tick_gen #(
  parameter int DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == CW'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bird_motion.sv
// Bird row position, flap pulse and gravity tick for the bounds checker.
// Define FLAP_BOOST_EN to make a flap-only update climb two rows instead of one.
module bird_motion
  import bird_pkg::*;
#(
  parameter int ROWS      = BIRD_ROWS,
  parameter int START_ROW = BIRD_START_ROW,
  parameter int GRAV_DIV  = 25000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key,
  input  logic                     hit,
  output logic [$clog2(ROWS)-1:0]  pos,
  output logic [ROWS-1:0]          bird_row,
  output logic                     key_pulse,
  output logic                     gravity,
  output logic                     top,
  output logic                     bottom,
  output logic                     flying
);

  localparam int             PW      = $clog2(ROWS);
  localparam logic [PW-1:0]  TOP_ROW = PW'(ROWS - 1);
  localparam logic [PW-1:0]  START   = PW'(START_ROW);

  bird_state_t   state, state_next;
  logic [PW-1:0] pos_next;
  logic          key_q;
  logic          rise;
  logic          tick;
  logic          pulse_next;
  logic          grav_next;

  logic [PW-1:0] pos_up1;
  logic [PW-1:0] pos_dn1;
  logic [PW-1:0] pos_flap;
  logic [PW-1:0] pos_both;

  assign rise = key && !key_q;

  tick_gen #(
    .DIV (GRAV_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state == FLY),
    .clr   (state != FLY),
    .tick  (tick)
  );

  // Saturating moves: the bird never wraps past the top or bottom row.
  assign pos_up1 = (pos == TOP_ROW) ? pos : pos + 1'b1;
  assign pos_dn1 = (pos == '0)      ? pos : pos - 1'b1;

`ifdef FLAP_BOOST_EN
  assign pos_flap = (pos >= PW'(ROWS - 2)) ? TOP_ROW : pos + PW'(2);
  assign pos_both = pos_up1;
`else
  assign pos_flap = pos_up1;
  assign pos_both = pos;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pos       <= START;
      key_q     <= 1'b0;
      key_pulse <= 1'b0;
      gravity   <= 1'b0;
    end else begin
      state     <= state_next;
      pos       <= pos_next;
      key_q     <= key;
      key_pulse <= pulse_next;
      gravity   <= grav_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pos_next   = pos;
    pulse_next = 1'b0;
    grav_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_next = FLY;
          pos_next   = pos_flap;
          pulse_next = 1'b1;
        end
      end
      FLY: begin
        // A hit freezes the bird on this edge and swallows any flap or tick.
        if (hit) begin
          state_next = DEAD;
        end else begin
          pulse_next = rise;
          grav_next  = tick;
          if (rise && tick) pos_next = pos_both;
          else if (rise)    pos_next = pos_flap;
          else if (tick)    pos_next = pos_dn1;
        end
      end
      DEAD: begin
        if (rise) begin
          state_next = IDLE;
          pos_next   = START;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bird_row = ROWS'(1) << pos;
  assign top      = (pos == TOP_ROW);
  assign bottom   = (pos == '0);
  assign flying   = (state == FLY);

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion (ROWS=8, START_ROW=4, GRAV_DIV=4, default build).
module tb_bird_motion;

  localparam int ROWS = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key = 1'b0;
  logic       hit = 1'b0;
  logic [2:0] pos;
  logic [7:0] bird_row;
  logic       key_pulse, gravity, top, bottom, flying;

  int tests = 0;
  int fails = 0;

  bird_motion #(
    .ROWS      (8),
    .START_ROW (4),
    .GRAV_DIV  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .hit       (hit),
    .pos       (pos),
    .bird_row  (bird_row),
    .key_pulse (key_pulse),
    .gravity   (gravity),
    .top       (top),
    .bottom    (bottom),
    .flying    (flying)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic key;
    logic hit;
    int   pos;
    logic pulse;
    logic grav;
    logic fly;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic k, input logic h, input int p,
                     input logic kp, input logic g, input logic f);
    vec_t v;
    v.rst = r; v.key = k; v.hit = h; v.pos = p; v.pulse = kp; v.grav = g; v.fly = f;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int p, input logic kp,
                           input logic g, input logic f);
    logic [7:0] row;
    row = 8'd1 << p;
    check({tag, ".pos"},       32'(pos),       32'(p));
    check({tag, ".bird_row"},  32'(bird_row),  32'(row));
    check({tag, ".key_pulse"}, 32'(key_pulse), 32'(kp));
    check({tag, ".gravity"},   32'(gravity),   32'(g));
    check({tag, ".flying"},    32'(flying),    32'(f));
    check({tag, ".top"},       32'(top),       32'(p == ROWS - 1));
    check({tag, ".bottom"},    32'(bottom),    32'(p == 0));
  endtask

  task automatic step(input logic r, input logic k, input logic h);
    reset = r; key = k; hit = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then 12 idle cycles with key low.
    add(1, 0, 0, 4, 0, 0, 0);
    for (int i = 0; i < 12; i++) add(0, 0, 0, 4, 0, 0, 0);
    // Key held 5 cycles: one pulse; the 5th edge already carries the first tick.
    add(0, 1, 0, 5, 1, 0, 1);
    add(0, 1, 0, 5, 0, 0, 1);
    add(0, 1, 0, 5, 0, 0, 1);
    add(0, 1, 0, 5, 0, 0, 1);
    add(0, 1, 0, 4, 0, 1, 1);
    // Key low: tick every 4th edge down to row 0, then one saturated tick.
    for (int t = 0; t < 5; t++) begin
      for (int q = 0; q < 3; q++) add(0, 0, 0, 4 - t, 0, 0, 1);
      add(0, 0, 0, (t < 4) ? 3 - t : 0, 0, 1, 1);
    end

    // Climb to the top; flaps on tick edges cancel, last flap saturates at 7.
    add(1, 0, 0, 4, 0, 0, 0);
    add(0, 1, 0, 5, 1, 0, 1);
    add(0, 0, 0, 5, 0, 0, 1);
    add(0, 1, 0, 6, 1, 0, 1);
    add(0, 0, 0, 6, 0, 0, 1);
    add(0, 1, 0, 6, 1, 1, 1);
    add(0, 0, 0, 6, 0, 0, 1);
    add(0, 1, 0, 7, 1, 0, 1);
    add(0, 0, 0, 7, 0, 0, 1);
    add(0, 1, 0, 7, 1, 1, 1);
    add(0, 0, 0, 7, 0, 0, 1);
    add(0, 1, 0, 7, 1, 0, 1);

    // Rise aligned with tick at row 3, then hit together with a rise at row 2.
    add(1, 0, 0, 4, 0, 0, 0);
    add(0, 1, 0, 5, 1, 0, 1);
    add(0, 0, 0, 5, 0, 0, 1);
    add(0, 0, 0, 5, 0, 0, 1);
    add(0, 0, 0, 5, 0, 0, 1);
    add(0, 0, 0, 4, 0, 1, 1);
    add(0, 0, 0, 4, 0, 0, 1);
    add(0, 0, 0, 4, 0, 0, 1);
    add(0, 0, 0, 4, 0, 0, 1);
    add(0, 0, 0, 3, 0, 1, 1);
    add(0, 0, 0, 3, 0, 0, 1);
    add(0, 0, 0, 3, 0, 0, 1);
    add(0, 0, 0, 3, 0, 0, 1);
    add(0, 1, 0, 3, 1, 1, 1);
    add(0, 0, 0, 3, 0, 0, 1);
    add(0, 0, 0, 3, 0, 0, 1);
    add(0, 0, 0, 3, 0, 0, 1);
    add(0, 0, 0, 2, 0, 1, 1);
    add(0, 0, 0, 2, 0, 0, 1);
    add(0, 1, 1, 2, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].key, vecs[i].hit);
      check_all($sformatf("vec%0d", i), vecs[i].pos, vecs[i].pulse, vecs[i].grav, vecs[i].fly);
    end

    // DEAD: key held high (no new rise) for 10 cycles, everything frozen.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0);
      check_all($sformatf("dead%0d", i), 2, 0, 0, 0);
    end
    step(0, 0, 0);
    check_all("dead_keylow", 2, 0, 0, 0);
    step(0, 1, 0);
    check_all("restart", 4, 0, 0, 0);

    // Fly up to row 6, then reset with key held high.
    step(0, 0, 0);
    check_all("idle_again", 4, 0, 0, 0);
    step(0, 1, 0);
    check_all("fly5", 5, 1, 0, 1);
    step(0, 0, 0);
    check_all("fly5_hold", 5, 0, 0, 1);
    step(0, 1, 0);
    check_all("fly6", 6, 1, 0, 1);
    step(1, 1, 0);
    check_all("mid_reset", 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      check_all($sformatf("post_reset%0d", i), 4, 0, 0, 0);
    end
    step(0, 1, 0);
    check_all("new_rise", 5, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bird_motion.md
Name: bird_motion

Overview:
Vertical-motion generator for the flappy-bird game; sits directly upstream of the out-of-bounds checker.
- Owns the bird's row position on the LED matrix.
- Turns the raw flap button into a single-cycle flap pulse.
- Generates the periodic gravity tick.
- Drives the flap, gravity, top and bottom signals the bounds checker consumes, and freezes when the game reports a hit.

Parameters:
ROWS, 8, number of matrix rows (>= 2); row 0 = bottom, ROWS-1 = top
START_ROW, 4, row loaded on reset and on restart; must be < ROWS
GRAV_DIV, 25000000, clk cycles per gravity tick (>= 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
key  in  1  flap button level, already synchronised, active-high
hit  in  1  game-over indication (bounds or collision), level
pos  out  $clog2(ROWS)  current bird row index
bird_row  out  ROWS  one-hot of pos
key_pulse  out  1  one-cycle flap pulse (feeds checker key)
gravity  out  1  one-cycle gravity tick (feeds checker gravity)
top  out  1  pos == ROWS-1
bottom  out  1  pos == 0
flying  out  1  state == FLY

Behaviour:
- Reset is synchronous, active-high; clock is clk.
- Reset values: state IDLE, pos = START_ROW, key_q = 0, tick counter = 0, key_pulse = 0, gravity = 0, flying = 0.
- bird_row, top and bottom are combinational from pos.
- Edge detect: key_q <= key every cycle. A rise means key = 1 and key_q = 0 at an edge.
- key_pulse is registered: high for exactly one cycle after a rise edge, in IDLE or FLY only. A held key gives one pulse.
- State machine (states IDLE, FLY, DEAD):
  - IDLE: pos holds; counter held at 0; gravity = 0. A rise goes to FLY, and the same edge applies the flap (pos + 1, saturating).
  - FLY: counter increments each cycle. At count GRAV_DIV-1 it wraps to 0 and gravity is registered high for one cycle (tick).
  - FLY -> DEAD when hit = 1. hit has priority over any flap or tick on that edge: pos is not updated, and key_pulse and gravity are 0 the next cycle.
  - DEAD: pos frozen; counter cleared; no key_pulse, no gravity. A rise goes to IDLE with pos <= START_ROW (restart).
- Position update in FLY, per edge:
  - flap only: pos <= min(pos + 1, ROWS-1).
  - tick only: pos <= max(pos - 1, 0).
  - flap and tick on the same edge: pos unchanged; key_pulse and gravity both asserted.
- Saturation never wraps. A flap at the top still raises key_pulse with top = 1, and a tick at the bottom still raises gravity with bottom = 1, so the downstream checker detects the violation.
- Latency: new pos, key_pulse and gravity all become visible together one edge after the causing event.
- Reset mid-flight: everything returns to reset values on the next edge, regardless of key or hit.

Optional Feature:
Macro FLAP_BOOST_EN.
- Defined: a flap-only update moves pos up 2 rows, saturating at ROWS-1. The flap+tick case moves pos up 1 row.
- Undefined: flap moves 1 row, as above.
- All other behaviour is identical.

Decomposition:
- Package bird_pkg holds:
  - bird_state_t enum (IDLE, FLY, DEAD)
  - default constants BIRD_ROWS = 8 and BIRD_START_ROW = 4
  - POS_W = $clog2(BIRD_ROWS)
- One sub-module, tick_gen, is natural: parameter DIV, inputs clk, reset, en, clr, output one-cycle tick. It holds the gravity counter.
- bird_motion instantiates tick_gen with en = (state == FLY) and clr = (state != FLY).

Test Plan:
All cases use ROWS = 8, START_ROW = 4, GRAV_DIV = 4.
- Reset, idle 12 cycles, key = 0 -> pos = 4, bird_row = 8'b0001_0000, gravity never asserted, flying = 0.
- key high for 5 cycles from IDLE -> exactly one key_pulse, pos = 5, flying = 1. Then, key low, gravity pulses every 4th cycle, pos steps 5..0, bottom = 1. One further tick -> pos stays 0, gravity = 1.
- 3 separate flaps from pos 4 with no tick in between -> pos = 7, top = 1. 4th flap -> pos stays 7, key_pulse = 1, top = 1.
- Rise edge aligned with the tick edge at pos 3 -> pos stays 3, key_pulse = 1 and gravity = 1 in the same cycle.
- hit = 1 at pos 2 in the same cycle as a rise -> DEAD, pos stays 2, no pulses for 10 cycles. Next rise -> IDLE, pos = 4.
- reset pulsed while flying at pos 6 with key high -> next cycle pos = 4, IDLE, all pulse outputs 0. A new rise is required to fly.
